// File: rtl/controller_pkg.sv
// Shared constants for the intersection controller front end: channel
// indices, default timing parameters and the common counter type.
package controller_pkg;

  localparam int CH_TA  = 0;
  localparam int CH_TB  = 1;
  localparam int CH_P   = 2;
  localparam int CH_R   = 3;
  localparam int NUM_CH = 4;

  localparam int DEBOUNCE_DEFAULT = 4;
  localparam int HOLD_DEFAULT     = 8;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchroniser followed by a debounce counter.
// rise/fall are strobes that are high in the cycle before deb changes, so a
// consumer registering on them updates on the same edge as deb itself.
module debounce_channel
  import controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic rise,
  output logic fall
);

  localparam cnt_t LAST = cnt_t'(DEBOUNCE_CYCLES - 1);

  logic s1;
  logic s2;
  cnt_t cnt;
  logic settle;

  // The new level has held for the full window and is accepted on this edge.
  assign settle = (s2 != deb) && (cnt == LAST);
  assign rise   = settle & s2;
  assign fall   = settle & ~s2;

  // Synchronise the raw input, then count consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the raw loop sensors and buttons for the mode/lights FSMs:
// ta/tb are debounced traffic levels stretched by a post-departure hold,
// p/r are single-cycle command pulses with release taking priority.
module traffic_sensor_conditioner
  import controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_ta,
  input  logic raw_tb,
  input  logic raw_p,
  input  logic raw_r,
  output logic ta,
  output logic tb,
  output logic p,
  output logic r
);

  localparam cnt_t HOLD_LOAD = cnt_t'(HOLD_CYCLES);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] deb;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [1:0]        traffic_q;

  // Button levels and release strobes are not needed; only their rise matters.
  logic unused_button_sigs;
  assign unused_button_sigs = ^{deb[CH_P], deb[CH_R], fall[CH_P], fall[CH_R]};

  assign raw[CH_TA] = raw_ta;
  assign raw[CH_TB] = raw_tb;
  assign raw[CH_P]  = raw_p;
  assign raw[CH_R]  = raw_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[g]),
      .deb  (deb[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  // Traffic channels occupy indices 0 and 1, so the loop index is the channel.
  for (genvar g = 0; g < 2; g++) begin : g_hold
    cnt_t hold;

    // Raise on debounced arrival, keep high for HOLD_CYCLES after departure.
    always_ff @(posedge clk) begin
      if (reset) begin
        hold         <= '0;
        traffic_q[g] <= 1'b0;
      end else if (rise[g]) begin
        hold         <= '0;
        traffic_q[g] <= 1'b1;
      end else if (fall[g]) begin
        if (HOLD_CYCLES > 0) begin
          hold         <= HOLD_LOAD;
          traffic_q[g] <= 1'b1;
        end else begin
          traffic_q[g] <= 1'b0;
        end
      end else if ((hold != '0) && !deb[g]) begin
        hold <= hold - 1'b1;
        if (hold == cnt_t'(1)) begin
          traffic_q[g] <= 1'b0;
        end
      end
    end
  end

  assign ta = traffic_q[CH_TA];
  assign tb = traffic_q[CH_TB];

  // Command pulses; a simultaneous parade press is dropped in favour of release.
  always_ff @(posedge clk) begin
    if (reset) begin
      p <= 1'b0;
      r <= 1'b0;
    end else begin
      r <= rise[CH_R];
      p <= rise[CH_P] & ~rise[CH_R];
    end
  end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner at DEBOUNCE=4, HOLD=8.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_traffic_sensor_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic raw_ta, raw_tb, raw_p, raw_r;
  logic ta, tb, p, r;

  int compared   = 0;
  int mismatched = 0;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .raw_ta(raw_ta),
    .raw_tb(raw_tb),
    .raw_p (raw_p),
    .raw_r (raw_r),
    .ta    (ta),
    .tb    (tb),
    .p     (p),
    .r     (r)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    {raw_ta, raw_tb, raw_p, raw_r} = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if ({ta, tb, p, r} !== 4'b0000) begin
        mismatched++;
        $display("FAIL reset_hold cycle %0d: got ta,tb,p,r=%b expected 0000", i, {ta, tb, p, r});
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      logic [3:0] exp;
      tick();
      exp = {(i >= 6), (i >= 6), 1'b0, (i == 6)};
      compared++;
      if ({ta, tb, p, r} !== exp) begin
        mismatched++;
        $display("FAIL reset_release edge %0d: got ta,tb,p,r=%b expected %b", i, {ta, tb, p, r}, exp);
      end
    end
    {raw_ta, raw_tb, raw_p, raw_r} = 4'b0000;
    repeat (20) tick();
    compared++;
    if ({ta, tb, p, r} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_settle: got ta,tb,p,r=%b expected 0000", {ta, tb, p, r});
    end
  endtask

  task automatic test_traffic;
    raw_ta = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      compared++;
      if (ta !== (i >= 6) || tb !== 1'b0) begin
        mismatched++;
        $display("FAIL traffic_rise edge %0d: got ta=%b tb=%b expected ta=%b tb=0", i, ta, tb, (i >= 6));
      end
    end
    raw_ta = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      compared++;
      if (ta !== (i < 14)) begin
        mismatched++;
        $display("FAIL traffic_hold edge %0d: got ta=%b expected %b", i, ta, (i < 14));
      end
    end
  endtask

  task automatic test_glitch;
    int seen;
    seen = 0;
    raw_tb = 1'b1;
    repeat (3) tick();
    raw_tb = 1'b0;
    repeat (12) begin
      tick();
      if (tb !== 1'b0) seen++;
    end
    compared++;
    if (seen != 0) begin
      mismatched++;
      $display("FAIL glitch_short: tb high %0d cycles expected 0", seen);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      raw_tb = ((i / 2) % 2) == 0;
      tick();
      if (tb !== 1'b0) seen++;
    end
    raw_tb = 1'b0;
    repeat (10) begin
      tick();
      if (tb !== 1'b0) seen++;
    end
    compared++;
    if (seen != 0) begin
      mismatched++;
      $display("FAIL glitch_toggle: tb high %0d cycles expected 0", seen);
    end
  endtask

  task automatic test_button_hold;
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    raw_p  = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (p === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    compared++;
    if (pulses != 1 || first != 6) begin
      mismatched++;
      $display("FAIL button_hold: got %0d pulses first at %0d expected 1 at 6", pulses, first);
    end
    raw_p = 1'b0;
    repeat (10) tick();
    pulses = 0;
    raw_p  = 1'b1;
    repeat (15) begin
      tick();
      if (p === 1'b1) pulses++;
    end
    raw_p = 1'b0;
    repeat (10) begin
      tick();
      if (p === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 1) begin
      mismatched++;
      $display("FAIL button_repress: got %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_simultaneous;
    int pc, rc, both;
    pc = 0; rc = 0; both = 0;
    raw_p = 1'b1;
    raw_r = 1'b1;
    repeat (20) begin
      tick();
      if (p === 1'b1) pc++;
      if (r === 1'b1) rc++;
      if (p === 1'b1 && r === 1'b1) both++;
    end
    compared++;
    if (pc != 0 || rc != 1 || both != 0) begin
      mismatched++;
      $display("FAIL simultaneous: got p=%0d r=%0d both=%0d expected p=0 r=1 both=0", pc, rc, both);
    end
    raw_r = 1'b0;
    pc = 0;
    repeat (15) begin
      tick();
      if (p === 1'b1) pc++;
    end
    compared++;
    if (pc != 0) begin
      mismatched++;
      $display("FAIL simultaneous_no_refire: got %0d p pulses expected 0", pc);
    end
    raw_p = 1'b0;
    repeat (10) tick();
    raw_p = 1'b1;
    pc = 0; rc = 0;
    repeat (12) begin
      tick();
      if (p === 1'b1) pc++;
      if (r === 1'b1) rc++;
    end
    raw_p = 1'b0;
    repeat (10) tick();
    compared++;
    if (pc != 1 || rc != 0) begin
      mismatched++;
      $display("FAIL simultaneous_repress: got p=%0d r=%0d expected p=1 r=0", pc, rc);
    end
  endtask

  task automatic test_hold_interrupt;
    int drops;
    raw_ta = 1'b1;
    repeat (10) tick();
    raw_ta = 1'b0;
    repeat (6) tick();
    compared++;
    if (ta !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_interrupt_enter: got ta=%b expected 1", ta);
    end
    raw_ta = 1'b1;
    drops  = 0;
    repeat (20) begin
      tick();
      if (ta !== 1'b1) drops++;
    end
    compared++;
    if (drops != 0) begin
      mismatched++;
      $display("FAIL hold_interrupt: ta low %0d cycles expected 0", drops);
    end
    raw_ta = 1'b0;
    repeat (16) tick();
    compared++;
    if (ta !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_interrupt_exit: got ta=%b expected 0", ta);
    end
  endtask

  task automatic test_reset_during_hold;
    int highs;
    raw_ta = 1'b1;
    repeat (10) tick();
    raw_ta = 1'b0;
    repeat (8) tick();
    compared++;
    if (ta !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_hold_pre: got ta=%b expected 1", ta);
    end
    reset = 1'b1;
    tick();
    compared++;
    if (ta !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_hold_abort: got ta=%b expected 0", ta);
    end
    reset = 1'b0;
    highs = 0;
    repeat (15) begin
      tick();
      if (ta !== 1'b0) highs++;
    end
    compared++;
    if (highs != 0) begin
      mismatched++;
      $display("FAIL reset_hold_residual: ta high %0d cycles expected 0", highs);
    end
  endtask

  initial begin
    reset  = 1'b1;
    raw_ta = 1'b0;
    raw_tb = 1'b0;
    raw_p  = 1'b0;
    raw_r  = 1'b0;
    test_reset();
    test_traffic();
    test_glitch();
    test_button_hold();
    test_simultaneous();
    test_hold_interrupt();
    test_reset_during_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
- Front end of the intersection controller; sits directly upstream of the mode/lights FSM pair.
- Takes raw asynchronous inputs: vehicle loop sensors for streets A and B, and the parade and release buttons.
- Synchronises and debounces each input.
- Produces clean outputs for the controller:
  - ta, tb: traffic-present levels, with a post-departure hold extension.
  - p, r: single-cycle command pulses.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples a new input level must hold before it is accepted; legal range 1..255.
- HOLD_CYCLES, 8: extra cycles ta/tb stay high after the debounced sensor falls; 0 disables the extension; legal range 0..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- raw_ta  in  1  street A vehicle sensor, asynchronous, may bounce
- raw_tb  in  1  street B vehicle sensor, asynchronous, may bounce
- raw_p  in  1  parade button, asynchronous, active-high
- raw_r  in  1  release button, asynchronous, active-high
- ta  out  1  street A traffic present (level, registered)
- tb  out  1  street B traffic present (level, registered)
- p  out  1  parade request, one-cycle pulse
- r  out  1  release request, one-cycle pulse

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - While reset is sampled high, every flop clears to 0: synchronisers, debounced levels, debounce counters, hold counters and outputs.
  - All outputs read 0 on the edge after reset is sampled and stay 0 while reset is held.
- Synchroniser: each raw input passes through a 2-flop synchroniser (s1, then s2).
- Debounce, per channel:
  - Each channel has a debounced level deb and a counter cnt.
  - If s2 equals deb, cnt clears to 0.
  - Otherwise cnt increments. On the edge where cnt equals DEBOUNCE_CYCLES-1 and s2 still differs, deb takes s2 and cnt clears.
  - Any sample agreeing with deb before then restarts the count; pulses shorter than the window are rejected.
  - Latency: deb changes on the (DEBOUNCE_CYCLES+2)th edge, counting the first edge that samples the new raw level. Default: 6th edge.
- Traffic outputs (ta; tb identical and independent):
  - deb rising: ta goes 1 on the same edge, and the hold counter clears.
  - deb falling with HOLD_CYCLES > 0: hold loads HOLD_CYCLES and ta remains 1.
  - While hold > 0 and deb = 0: hold decrements each edge. ta goes 0 on the edge where hold decrements from 1 to 0, i.e. HOLD_CYCLES edges after deb fell.
  - deb re-rising during hold: hold clears and ta stays 1.
  - HOLD_CYCLES = 0: ta follows deb exactly.
- Command outputs (p, r):
  - Each fires for exactly one cycle on the edge where its deb rises.
  - No further pulse until deb has fallen and risen again; holding a button never repeats.
  - If p and r would fire on the same edge, only r is emitted and that p event is discarded. It does not re-fire later for that press.
  - p and r are never high in the same cycle.
- No combinational path from any input to any output.
- Reset mid-operation aborts any pending debounce, hold or pulse.
  - After reset deasserts, deb = 0. A button still held therefore produces a fresh pulse once it has debounced.

Decomposition:
- Shared package controller_pkg holds:
  - Channel index constants: CH_TA = 0, CH_TB = 1, CH_P = 2, CH_R = 3; NUM_CH = 4.
  - Defaults: DEBOUNCE_DEFAULT = 4, HOLD_DEFAULT = 8.
  - Counter width constant: CNT_W = 8.
- Sub-module debounce_channel contains the synchroniser, counter and deb register for one channel. Outputs deb, rise and fall.
  - It is instantiated four times.
  - Hold logic and the p/r priority live in the top level.

Test Plan (DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 8):
- Reset: all raw inputs 1 with reset held for 10 cycles -> ta, tb, p, r = 0 throughout. Release reset -> ta = 1 on the 6th edge after release, and p and r each pulse once, on that edge, only if their buttons are not simultaneous (otherwise r only).
- Traffic: raw_ta rises and is first sampled at edge k -> ta = 1 after edge k+5. raw_ta falls and is first sampled at edge j -> deb falls at j+5 and ta = 0 after edge j+13.
- Glitch: raw_tb high for 3 cycles, then low -> tb stays 0. raw_tb toggling every 2 cycles for 40 cycles -> tb stays 0.
- Button hold: raw_p high for 30 cycles -> p high for exactly one cycle, after edge k+5. Release and re-press -> exactly one further pulse.
- Simultaneous buttons: raw_p and raw_r rise in the same cycle -> single r pulse; p stays 0 until raw_p is released and re-pressed.
- Hold interrupted: ta in hold with 3 cycles remaining, raw_ta debounced high again -> ta never drops. Alternatively, reset asserted during hold -> ta = 0 on the next edge, with no residual extension after reset is released.
